// File: rtl/jt08_adpcm_seq.sv
// Time-multiplexed ADPCM ROM address sequencer: one channel slot per cen6, nibble-granular playback.
// Optional looping playback is enabled by defining JT08_ADPCM_LOOP_EN.
module jt08_adpcm_seq #(
    parameter int CH = 6,
    parameter int AW = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cen6,
    input  logic [15:0]           addr_in,
    input  logic [$clog2(CH)-1:0] up_ch,
    input  logic                  up_start,
    input  logic                  up_end,
    input  logic [CH:0]           aon_cmd,
    input  logic                  up_aon,
    input  logic [CH-1:0]         flag_clr,
    input  logic [CH-1:0]         loop,
    output logic [CH-1:0]         cur_ch,
    output logic [AW-1:0]         addr,
    output logic                  sel,
    output logic                  roe_n,
    output logic                  decon,
    output logic                  clr,
    output logic [CH-1:0]         eos
);
    localparam int CW = $clog2(CH);
    localparam int NW = AW + 1;

    logic [CH-1:0] cur_ch_q, cur_ch_d;
    logic [15:0]   start_q [CH];
    logic [15:0]   start_d [CH];
    logic [15:0]   end_q   [CH];
    logic [15:0]   end_d   [CH];
    logic [NW-1:0] cnt_q   [CH];
    logic [NW-1:0] cnt_d   [CH];
    logic [CH-1:0] act_q, act_d;
    logic [CH-1:0] pon_q, pon_d;
    logic [CH-1:0] poff_q, poff_d;
    logic [CH-1:0] relo_q, relo_d;
    logic [CH-1:0] eos_q, eos_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          sel_q, sel_d;
    logic          roe_n_q, roe_n_d;
    logic          decon_q, decon_d;
    logic          clr_q, clr_d;

    logic [CW-1:0] ch_idx;
    logic [NW-1:0] start_nib;
    logic [NW-1:0] last_nib;
    logic [NW-1:0] cur_nib;

`ifndef JT08_ADPCM_LOOP_EN
    logic unused_loop;
    assign unused_loop = ^loop;
`endif

    always_comb begin
        ch_idx = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (cur_ch_q[i]) ch_idx = CW'(i);
        end
        // Nibble addresses: {reg, byte, nibble}, truncated to the counter width
        start_nib = NW'({start_q[ch_idx], 9'h000});
        last_nib  = NW'({end_q[ch_idx], 9'h1FF});
        cur_nib   = cnt_q[ch_idx];
    end

    always_comb begin
        cur_ch_d = cur_ch_q;
        start_d  = start_q;
        end_d    = end_q;
        cnt_d    = cnt_q;
        act_d    = act_q;
        pon_d    = pon_q;
        poff_d   = poff_q;
        relo_d   = relo_q;
        eos_d    = eos_q & ~flag_clr;
        addr_d   = addr_q;
        sel_d    = sel_q;
        roe_n_d  = roe_n_q;
        decon_d  = decon_q;
        clr_d    = clr_q;

        if (cen6) begin
            cur_ch_d       = {cur_ch_q[CH-2:0], cur_ch_q[CH-1]};
            pon_d[ch_idx]  = 1'b0;
            poff_d[ch_idx] = 1'b0;
            roe_n_d        = 1'b1;
            decon_d        = 1'b0;
            clr_d          = 1'b0;
            if (poff_q[ch_idx]) begin
                act_d[ch_idx]  = 1'b0;
                relo_d[ch_idx] = 1'b0;
            end else if (pon_q[ch_idx] || (act_q[ch_idx] && relo_q[ch_idx])) begin
                // Key-on and loop restart both begin at the start nibble with a predictor clear
                addr_d         = start_nib[AW:1];
                sel_d          = start_nib[0];
                roe_n_d        = 1'b0;
                decon_d        = 1'b1;
                clr_d          = 1'b1;
                cnt_d[ch_idx]  = start_nib + NW'(1);
                act_d[ch_idx]  = 1'b1;
                relo_d[ch_idx] = 1'b0;
                if (pon_q[ch_idx]) eos_d[ch_idx] = 1'b0;
            end else if (act_q[ch_idx]) begin
                addr_d        = cur_nib[AW:1];
                sel_d         = cur_nib[0];
                roe_n_d       = 1'b0;
                decon_d       = 1'b1;
                cnt_d[ch_idx] = cur_nib + NW'(1);
                if (cur_nib == last_nib) begin
                    eos_d[ch_idx] = 1'b1;
`ifdef JT08_ADPCM_LOOP_EN
                    if (loop[ch_idx]) relo_d[ch_idx] = 1'b1;
                    else              act_d[ch_idx]  = 1'b0;
`else
                    act_d[ch_idx] = 1'b0;
`endif
                end
            end
        end

        if (up_start && (int'(up_ch) < CH)) start_d[up_ch] = addr_in;
        if (up_end && (int'(up_ch) < CH))   end_d[up_ch]   = addr_in;

        // New commands are merged after the served slot's clear so they are never lost
        if (up_aon) begin
            if (aon_cmd[CH]) poff_d = poff_d | aon_cmd[CH-1:0];
            else             pon_d  = pon_d | aon_cmd[CH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_ch_q <= CH'(1);
            for (int unsigned i = 0; i < CH; i++) begin
                start_q[i] <= '0;
                end_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
            act_q   <= '0;
            pon_q   <= '0;
            poff_q  <= '0;
            relo_q  <= '0;
            eos_q   <= '0;
            addr_q  <= '0;
            sel_q   <= 1'b0;
            roe_n_q <= 1'b1;
            decon_q <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            cur_ch_q <= cur_ch_d;
            start_q  <= start_d;
            end_q    <= end_d;
            cnt_q    <= cnt_d;
            act_q    <= act_d;
            pon_q    <= pon_d;
            poff_q   <= poff_d;
            relo_q   <= relo_d;
            eos_q    <= eos_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            roe_n_q  <= roe_n_d;
            decon_q  <= decon_d;
            clr_q    <= clr_d;
        end
    end

    assign cur_ch = cur_ch_q;
    assign addr   = addr_q;
    assign sel    = sel_q;
    assign roe_n  = roe_n_q;
    assign decon  = decon_q;
    assign clr    = clr_q;
    assign eos    = eos_q;

endmodule

// File: tb/tb_jt08_adpcm_seq.sv
// Testbench for jt08_adpcm_seq: playback-position reference model plus directed scenario checks.
// Loop scenarios follow JT08_ADPCM_LOOP_EN when it is defined for the build.
module tb_jt08_adpcm_seq;
    localparam int CH = 6;
    localparam int AW = 20;
    localparam int unsigned M = 1 << (AW + 1);

    logic                  clk;
    logic                  rst_n;
    logic                  cen6;
    logic [15:0]           addr_in;
    logic [$clog2(CH)-1:0] up_ch;
    logic                  up_start;
    logic                  up_end;
    logic [CH:0]           aon_cmd;
    logic                  up_aon;
    logic [CH-1:0]         flag_clr;
    logic [CH-1:0]         loop;
    logic [CH-1:0]         cur_ch;
    logic [AW-1:0]         addr;
    logic                  sel;
    logic                  roe_n;
    logic                  decon;
    logic                  clr;
    logic [CH-1:0]         eos;

    jt08_adpcm_seq #(.CH(CH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .cen6(cen6), .addr_in(addr_in), .up_ch(up_ch),
        .up_start(up_start), .up_end(up_end), .aon_cmd(aon_cmd), .up_aon(up_aon),
        .flag_clr(flag_clr), .loop(loop), .cur_ch(cur_ch), .addr(addr), .sel(sel),
        .roe_n(roe_n), .decon(decon), .clr(clr), .eos(eos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each channel plays nibble positions first..last (mod M)
    int unsigned   m_start [CH];
    int unsigned   m_end   [CH];
    int unsigned   m_pos   [CH];
    bit            m_act   [CH];
    bit            m_pon   [CH];
    bit            m_poff  [CH];
    bit            m_relo  [CH];
    logic [CH-1:0] m_eos;
    int            m_slot;
    logic [AW-1:0] e_addr;
    logic          e_sel, e_roe_n, e_decon, e_clr;

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_start[i] = 0; m_end[i] = 0; m_pos[i] = 0;
            m_act[i] = 0; m_pon[i] = 0; m_poff[i] = 0; m_relo[i] = 0;
        end
        m_eos = '0; m_slot = 0;
        e_addr = '0; e_sel = 1'b0; e_roe_n = 1'b1; e_decon = 1'b0; e_clr = 1'b0;
    endtask

    task automatic present(input int unsigned p, input bit is_clr);
        e_addr  = AW'(p >> 1);
        e_sel   = p[0];
        e_roe_n = 1'b0;
        e_decon = 1'b1;
        e_clr   = is_clr;
    endtask

    task automatic model_edge();
        logic [CH-1:0] nx;
        int unsigned first, last, p;
        int c;
        nx = m_eos & ~flag_clr;
        if (cen6) begin
            c = m_slot;
            first = (m_start[c] * 512) % M;
            last  = (m_end[c] * 512 + 511) % M;
            e_roe_n = 1'b1; e_decon = 1'b0; e_clr = 1'b0;
            if (m_poff[c]) begin
                m_act[c] = 0; m_relo[c] = 0;
            end else if (m_pon[c] || (m_act[c] && m_relo[c])) begin
                present(first, 1'b1);
                m_pos[c] = (first + 1) % M;
                m_act[c] = 1; m_relo[c] = 0;
                if (m_pon[c]) nx[c] = 1'b0;
            end else if (m_act[c]) begin
                p = m_pos[c];
                present(p, 1'b0);
                m_pos[c] = (p + 1) % M;
                if (p == last) begin
                    nx[c] = 1'b1;
`ifdef JT08_ADPCM_LOOP_EN
                    if (loop[c]) m_relo[c] = 1; else m_act[c] = 0;
`else
                    m_act[c] = 0;
`endif
                end
            end
            m_pon[c] = 0; m_poff[c] = 0;
            m_slot = (m_slot + 1) % CH;
        end
        if (up_start && int'(up_ch) < CH) m_start[up_ch] = addr_in;
        if (up_end && int'(up_ch) < CH)   m_end[up_ch]   = addr_in;
        if (up_aon) begin
            for (int i = 0; i < CH; i++) begin
                if (aon_cmd[i]) begin
                    if (aon_cmd[CH]) m_poff[i] = 1; else m_pon[i] = 1;
                end
            end
        end
        m_eos = nx;
    endtask

    task automatic tick();
        logic [CH-1:0] e_cur;
        @(posedge clk);
        model_edge();
        #1;
        e_cur = '0;
        e_cur[m_slot] = 1'b1;
        n_tests++;
        if ({cur_ch, addr, sel, roe_n, decon, clr, eos} !==
            {e_cur, e_addr, e_sel, e_roe_n, e_decon, e_clr, m_eos}) begin
            n_fail++;
            $display("FAIL cycle_outputs t=%0t: got cur=%b addr=%h sel=%b roe_n=%b decon=%b clr=%b eos=%b; required cur=%b addr=%h sel=%b roe_n=%b decon=%b clr=%b eos=%b",
                     $time, cur_ch, addr, sel, roe_n, decon, clr, eos,
                     e_cur, e_addr, e_sel, e_roe_n, e_decon, e_clr, m_eos);
        end
    endtask

    task automatic slot();
        repeat ($urandom_range(0, 2)) begin
            cen6 = 1'b0;
            tick();
        end
        cen6 = 1'b1;
        tick();
        cen6 = 1'b0;
    endtask

    task automatic run_to_slot(input int c);
        for (int k = 0; k < CH && m_slot != c; k++) slot();
    endtask

    task automatic write_regs(input int ch, input logic [15:0] s, input logic [15:0] e);
        up_ch = ($clog2(CH))'(ch);
        addr_in = s; up_start = 1'b1; tick(); up_start = 1'b0;
        addr_in = e; up_end = 1'b1;   tick(); up_end = 1'b0;
    endtask

    task automatic key(input bit off, input logic [CH-1:0] mask);
        aon_cmd = {off, mask}; up_aon = 1'b1; tick(); up_aon = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cen6 = 1'b0; addr_in = '0; up_ch = '0; up_start = 1'b0; up_end = 1'b0;
        aon_cmd = '0; up_aon = 1'b0; flag_clr = '0; loop = '0;
        model_reset();
        #12;
        n_tests++;
        if ({cur_ch, addr, sel, roe_n, decon, clr, eos} !== {6'b000001, 20'h0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got cur=%b addr=%h sel=%b roe_n=%b decon=%b clr=%b eos=%b; required 000001/00000/0/1/0/0/000000",
                     cur_ch, addr, sel, roe_n, decon, clr, eos);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) slot();
    endtask

    task automatic test_single_sample();
        write_regs(2, 16'h0010, 16'h0010);
        key(1'b0, 6'b000100);
        flag_clr = 6'b000100;
        run_to_slot(2);
        slot();
        n_tests++;
        if (addr !== 20'h01000 || sel !== 1'b0 || clr !== 1'b1 || decon !== 1'b1) begin
            n_fail++;
            $display("FAIL single_first: got addr=%h sel=%b clr=%b decon=%b; required 01000/0/1/1", addr, sel, clr, decon);
        end
        for (int k = 1; k < 512; k++) repeat (CH) slot();
        n_tests++;
        if (addr !== 20'h010FF || sel !== 1'b1 || eos[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_last_eos: got addr=%h sel=%b eos2=%b; required 010FF/1/1", addr, sel, eos[2]);
        end
        flag_clr = '0;
        repeat (CH) slot();
        n_tests++;
        if (roe_n !== 1'b1 || decon !== 1'b0 || eos[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_stopped: got roe_n=%b decon=%b eos2=%b; required 1/0/1", roe_n, decon, eos[2]);
        end
    endtask

    task automatic test_dual();
        logic [15:0] r0, r5;
        logic [AW-1:0] a0, a5;
        r0 = 16'($urandom); r5 = 16'($urandom);
        a0 = AW'((r0 * 256) % (1 << AW));
        a5 = AW'((r5 * 256) % (1 << AW));
        write_regs(0, r0, r0);
        write_regs(5, r5, r5);
        key(1'b0, 6'b100001);
        run_to_slot(0);
        for (int k = 0; k < CH; k++) begin
            slot();
            n_tests++;
            if (k == 0 && (decon !== 1'b1 || addr !== a0)) begin
                n_fail++;
                $display("FAIL dual_ch0: got decon=%b addr=%h; required 1/%h", decon, addr, a0);
            end else if (k == 5 && (decon !== 1'b1 || addr !== a5)) begin
                n_fail++;
                $display("FAIL dual_ch5: got decon=%b addr=%h; required 1/%h", decon, addr, a5);
            end else if (k != 0 && k != 5 && decon !== 1'b0) begin
                n_fail++;
                $display("FAIL dual_idle_slot%0d: got decon=%b; required 0", k, decon);
            end
        end
        n_tests++;
        if (cur_ch !== 6'b000001) begin
            n_fail++;
            $display("FAIL dual_rotation: got cur_ch=%b; required 000001", cur_ch);
        end
        repeat (4 * CH) slot();
        key(1'b1, 6'b100001);
        repeat (2 * CH) slot();
    endtask

    task automatic test_keyoff();
        write_regs(1, 16'($urandom), 16'($urandom));
        key(1'b0, 6'b000010);
        repeat (10 * CH) slot();
        key(1'b1, 6'b000010);
        run_to_slot(1);
        slot();
        n_tests++;
        if (decon !== 1'b0 || roe_n !== 1'b1 || eos[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL keyoff: got decon=%b roe_n=%b eos1=%b; required 0/1/0", decon, roe_n, eos[1]);
        end
        repeat (2 * CH) slot();
    endtask

    task automatic test_loop();
        write_regs(3, 16'h0001, 16'h0001);
        loop = 6'b001000;
        key(1'b0, 6'b001000);
        run_to_slot(3);
        slot();
        n_tests++;
        if (addr !== 20'h00100 || clr !== 1'b1) begin
            n_fail++;
            $display("FAIL loop_first: got addr=%h clr=%b; required 00100/1", addr, clr);
        end
        for (int k = 1; k < 512; k++) repeat (CH) slot();
        n_tests++;
        if (addr !== 20'h001FF || sel !== 1'b1 || eos[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL loop_last: got addr=%h sel=%b eos3=%b; required 001FF/1/1", addr, sel, eos[3]);
        end
        repeat (CH) slot();
        n_tests++;
`ifdef JT08_ADPCM_LOOP_EN
        if (addr !== 20'h00100 || sel !== 1'b0 || clr !== 1'b1 || decon !== 1'b1 || eos[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL loop_restart: got addr=%h sel=%b clr=%b decon=%b eos3=%b; required 00100/0/1/1/1",
                     addr, sel, clr, decon, eos[3]);
        end
`else
        if (roe_n !== 1'b1 || decon !== 1'b0 || clr !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_ignored: got roe_n=%b decon=%b clr=%b; required 1/0/0", roe_n, decon, clr);
        end
`endif
        loop = '0;
        key(1'b1, 6'b001000);
        repeat (2 * CH) slot();
    endtask

    task automatic test_random();
        for (int it = 0; it < 2500; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                logic [15:0] v;
                v = 16'($urandom);
                write_regs(int'($urandom_range(0, 7)), v, v + 16'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 29) == 0) key(1'($urandom_range(0, 3) == 0), CH'($urandom));
            flag_clr = ($urandom_range(0, 9) == 0) ? CH'($urandom) : '0;
`ifdef JT08_ADPCM_LOOP_EN
            if ($urandom_range(0, 49) == 0) loop = CH'($urandom);
`endif
            slot();
        end
        flag_clr = '0;
    endtask

    task automatic test_reset_mid();
        int seen;
        write_regs(4, 16'h1234, 16'h1234);
        key(1'b0, 6'b111111);
        repeat (2 * CH) slot();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({cur_ch, addr, sel, roe_n, decon, clr, eos} !== {6'b000001, 20'h0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: got cur=%b addr=%h sel=%b roe_n=%b decon=%b clr=%b eos=%b; required 000001/00000/0/1/0/0/000000",
                     cur_ch, addr, sel, roe_n, decon, clr, eos);
        end
        model_reset();
        loop = '0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 3 * CH; k++) begin
            slot();
            if (decon === 1'b1 || roe_n !== 1'b1) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_no_play: got %0d playing slots; required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_single_sample();
        test_dual();
        test_keyoff();
        test_loop();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
